node_io: RTL and testbench

- One node port on the shared multipoint interposer bus.
- Injects locally generated messages into a small transmit queue and raises a send request (destination carried with it) to the bus arbiter.
- Under arbiter control, the node sends, receives, or bypasses on the bus. Received messages addressed to this node are delivered locally; others are queued for forwarding.

---
 rtl/node_io.sv | 108 ++++++++++
 tb/tb_node_io.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/node_io.sv
// Node port on the shared multipoint bus: transmit queue, send request, delivery and bypass.
// Define TRISTATE_BUS_EN to release msg_out (22'bz) whenever this node is not driving the bus.
module node_io #(
   parameter int NODE_NUMBER = 0,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [21:0] msg_in,
   input  logic [21:0] msg_rand,
   input  logic [2:0]  control_in,
   output logic [21:0] msg_out,
   output logic [19:0] msg_received,
   output logic [3:0]  request_out
);

   localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [2:0]    NODE_ID  = 3'(NODE_NUMBER);
   localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_DEPTH);

   logic [21:0]   queue_mem [QUEUE_DEPTH];
   logic [PW-1:0] head_reg, tail_reg, head_next;
   logic [CW-1:0] count_reg, count_next, remain_after_pop;
   logic [21:0]   last_rand_reg;

   logic send_cmd, recv_cmd, bypass_cmd;
   logic q_empty, q_full, pop;
   logic rx_valid, rx_local, fwd_push;
   logic rand_new, rand_local, inj_push, rand_take, push;
   logic [21:0] push_data, head_msg;
   logic [2:0]  next_head_dest;
   logic [3:0]  request_next;

   always_comb begin
      send_cmd   = (control_in == 3'b100);
      recv_cmd   = (control_in == 3'b010);
      bypass_cmd = (control_in == 3'b001);

      q_empty  = (count_reg == '0);
      q_full   = (count_reg == FULL_CNT);
      head_msg = queue_mem[head_reg];
      pop      = send_cmd && !q_empty;

      rx_valid = recv_cmd && (msg_in != '0);
      rx_local = rx_valid && (msg_in[21:19] == NODE_ID);
      fwd_push = rx_valid && !rx_local && !q_full;

      // A pop frees the slot, so a full queue can still accept an injection that cycle.
      rand_new   = (msg_rand != '0) && (msg_rand != last_rand_reg);
      rand_local = (msg_rand[21:19] == NODE_ID);
      inj_push   = rand_new && !rand_local && !fwd_push && (!q_full || pop);
      rand_take  = rand_new && (rand_local || inj_push);

      push      = fwd_push || inj_push;
      push_data = fwd_push ? msg_in : msg_rand;

      head_next        = pop ? head_reg + PW'(1) : head_reg;
      count_next       = count_reg + CW'(push) - CW'(pop);
      remain_after_pop = count_reg - CW'(pop);
      // When nothing survives the pop, the pushed message becomes the new head.
      next_head_dest   = (remain_after_pop == '0) ? push_data[21:19]
                                                  : queue_mem[head_next][21:19];
      request_next     = (count_next != '0) ? {1'b1, next_head_dest} : 4'b0;
   end

   always_comb begin
`ifdef TRISTATE_BUS_EN
      msg_out = 'z;
`else
      msg_out = '0;
`endif
      if (pop)
         msg_out = head_msg;
      else if (bypass_cmd)
         msg_out = msg_in;
   end

   always_ff @(posedge clk) begin
      if (push)
         queue_mem[tail_reg] <= push_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_reg      <= '0;
         tail_reg      <= '0;
         count_reg     <= '0;
         last_rand_reg <= '0;
         msg_received  <= '0;
         request_out   <= '0;
      end else begin
         head_reg    <= head_next;
         count_reg   <= count_next;
         request_out <= request_next;
         if (push)
            tail_reg <= tail_reg + PW'(1);
         if (rand_take)
            last_rand_reg <= msg_rand;
         // Valid pulses for one cycle; payload holds until the next delivery.
         if (rx_local)
            msg_received <= {1'b1, msg_in[18:0]};
         else
            msg_received[19] <= 1'b0;
      end
   end

endmodule

// File: tb/tb_node_io.sv
// Directed self-checking bench for node_io using a node-4 and a node-5 instance on shared inputs.
module tb_node_io;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [21:0] msg_in = '0;
   logic [21:0] msg_rand = '0;
   logic [2:0]  control_in = '0;
   logic [21:0] out4, out5;
   logic [19:0] rcv4, rcv5;
   logic [3:0]  req4, req5;

   int checks = 0;
   int failures = 0;

   localparam logic [21:0] M1 = 22'b1011001010101010101111;
   localparam logic [21:0] M2 = 22'b1100000000000000000001;
   localparam logic [21:0] MB = 22'b1011001010101010110011;
   localparam logic [21:0] MS = 22'b1000010010001101000101;
   localparam logic [21:0] MF = 22'b1101001010101010101111;
   localparam logic [21:0] XF = 22'b1100101111001101111001;

   logic [21:0] q [5];

   node_io #(.NODE_NUMBER(4), .QUEUE_DEPTH(4)) u4 (
      .clk(clk), .reset(reset), .msg_in(msg_in), .msg_rand(msg_rand),
      .control_in(control_in), .msg_out(out4), .msg_received(rcv4), .request_out(req4)
   );

   node_io #(.NODE_NUMBER(5), .QUEUE_DEPTH(4)) u5 (
      .clk(clk), .reset(reset), .msg_in(msg_in), .msg_rand(msg_rand),
      .control_in(control_in), .msg_out(out5), .msg_received(rcv5), .request_out(req5)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic reset_dut();
      msg_rand   = '0;
      msg_in     = '0;
      control_in = '0;
      reset      = 1'b0;
      #3;
      reset      = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      q[0] = {3'd1, 19'h00011};
      q[1] = {3'd2, 19'h00022};
      q[2] = {3'd3, 19'h00033};
      q[3] = {3'd6, 19'h00044};
      q[4] = {3'd7, 19'h00055};

      // Reset held with traffic present
      #3;
      reset      = 1'b0;
      msg_rand   = M1;
      msg_in     = MF;
      control_in = 3'b010;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_msg_out", 32'(out4), 32'h0);
      chk("rst_rcv4", 32'(rcv4), 32'h0);
      chk("rst_req4", 32'(req4), 32'h0);
      chk("rst_rcv5", 32'(rcv5), 32'h0);
      msg_rand   = '0;
      msg_in     = '0;
      control_in = '0;
      reset      = 1'b1;
      tick();
      chk("post_rst_msg_out", 32'(out4), 32'h0);
      chk("post_rst_req4", 32'(req4), 32'h0);

      // Local injection on node 4
      msg_rand = M1;
      tick();
      chk("inj_req", 32'(req4), 32'hD);
      control_in = 3'b100;
      #1;
      chk("inj_send_out", 32'(out4), 32'(M1));
      tick();
      chk("inj_req_after_pop", 32'(req4), 32'h0);
      control_in = 3'b000;
      #1;
      chk("idle_out", 32'(out4), 32'h0);
      tick();
      chk("no_reinject", 32'(req4), 32'h0);

      // Message addressed to node 4 itself is discarded
      msg_rand = MS;
      tick();
      chk("self_discard", 32'(req4), 32'h0);

      // Bypass while one message is queued
      msg_rand = M2;
      tick();
      chk("bp_pre_req", 32'(req4), 32'hE);
      control_in = 3'b001;
      msg_in     = MB;
      #1;
      chk("bypass_out", 32'(out4), 32'(MB));
      tick();
      chk("bp_req_kept", 32'(req4), 32'hE);
      chk("bp_rcv_kept", 32'(rcv4), 32'h0);
      control_in = 3'b100;
      msg_in     = '0;
      #1;
      chk("bp_send_out", 32'(out4), 32'(M2));
      tick();
      chk("bp_req_after_pop", 32'(req4), 32'h0);

      // Delivery and forward on node 5
      reset_dut();
      tick();
      msg_in     = M1;
      control_in = 3'b010;
      tick();
      chk("deliver", 32'(rcv5), 32'(20'b1_1001010101010101111));
      msg_in     = '0;
      control_in = 3'b000;
      tick();
      chk("deliver_valid_clr", 32'(rcv5), 32'(20'b0_1001010101010101111));
      msg_in     = MF;
      control_in = 3'b010;
      tick();
      chk("fwd_req", 32'(req5), 32'hE);
      chk("fwd_rcv_held", 32'(rcv5), 32'(20'b0_1001010101010101111));
      msg_in     = '0;
      control_in = 3'b100;
      #1;
      chk("fwd_send_out", 32'(out5), 32'(MF));
      tick();
      chk("fwd_req_after_pop", 32'(req5), 32'h0);

      // Overflow on node 4: fill, drop forward, defer injection, then drain
      reset_dut();
      tick();
      for (int i = 0; i < 4; i++) begin
         msg_rand = q[i];
         tick();
         chk($sformatf("fill_req_%0d", i), 32'(req4), 32'h9);
      end
      msg_in     = XF;
      control_in = 3'b010;
      tick();
      chk("ovf_drop_req", 32'(req4), 32'h9);
      msg_in     = '0;
      control_in = 3'b000;
      msg_rand   = q[4];
      tick();
      chk("full_defer_req", 32'(req4), 32'h9);
      control_in = 3'b100;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("drain_out_%0d", i), 32'(out4), 32'(q[i]));
         tick();
         chk($sformatf("drain_req_%0d", i), 32'(req4),
             (i < 4) ? {28'h0, 1'b1, q[i+1][21:19]} : 32'h0);
      end
      #1;
      chk("drain_empty_out", 32'(out4), 32'h0);
      control_in = 3'b000;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
